// File: rtl/vec_op_seq.sv
// Vector operation sequencer: streams operand pairs from the scratchpad
// through the external combinational ALU and writes results back.
module vec_op_seq #(
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_opcode,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [63:0]       cmd_q,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr_a,
    output logic [ADDR_W-1:0] rd_addr_b,
    input  logic [63:0]       rd_data_a,
    input  logic [63:0]       rd_data_b,
    output logic [2:0]        alu_opcode,
    output logic [63:0]       alu_a,
    output logic [63:0]       alu_b,
    output logic [63:0]       alu_q,
    input  logic [63:0]       alu_res,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [63:0]       wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t             state;
    state_t             state_n;
    logic [2:0]         op_q;
    logic [ADDR_W-1:0]  sa_q;
    logic [ADDR_W-1:0]  sb_q;
    logic [ADDR_W-1:0]  d_q;
    logic [LEN_W-1:0]   len_q;
    logic [63:0]        q_q;
    logic [LEN_W-1:0]   rd_idx;
    logic [ADDR_W-1:0]  wr_idx;
    logic               v1;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [63:0]        wr_data_q;
    logic               rdy_q;
    logic               done_q;
    logic               err_q;
    logic               accept;
    logic               legal;
    logic               start;
    logic               quick;
    logic               fin;

    assign accept = cmd_valid && rdy_q;
    assign legal  = cmd_opcode <= 3'd2;
    assign start  = accept && legal && (cmd_len != '0);
    // Empty or illegal commands complete without touching memory
    assign quick  = accept && !start;

    always_comb begin
        state_n = state;
        fin     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_n = RUN;
            end
            RUN: begin
                if (rd_idx == len_q - LEN_ONE) state_n = DRAIN;
            end
            DRAIN: begin
                // Last write is on the bus once no read data is pending
                if (wr_en_q && !v1) begin
                    state_n = IDLE;
                    fin     = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            op_q      <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            d_q       <= '0;
            len_q     <= '0;
            q_q       <= '0;
            rd_idx    <= '0;
            wr_idx    <= '0;
            v1        <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rdy_q     <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state   <= state_n;
            rdy_q   <= (state_n == IDLE) && !quick;
            done_q  <= fin || quick;
            err_q   <= quick && !legal;
            v1      <= (state == RUN);
            wr_en_q <= v1;
            if (accept) begin
                op_q   <= cmd_opcode;
                sa_q   <= cmd_src_a;
                sb_q   <= cmd_src_b;
                d_q    <= cmd_dst;
                len_q  <= cmd_len;
                q_q    <= cmd_q;
                rd_idx <= '0;
                wr_idx <= '0;
            end else if (state == RUN) begin
                rd_idx <= rd_idx + LEN_ONE;
            end
            if (v1) begin
                wr_addr_q <= d_q + wr_idx;
                wr_data_q <= alu_res;
                wr_idx    <= wr_idx + ADDR_ONE;
            end
        end
    end

    assign cmd_ready  = rdy_q;
    assign busy       = (state != IDLE);
    assign rd_en      = (state == RUN);
    assign rd_addr_a  = sa_q + rd_idx[ADDR_W-1:0];
    assign rd_addr_b  = sb_q + rd_idx[ADDR_W-1:0];
    // Operands are forced to zero when no read data is in flight
    assign alu_a      = v1 ? rd_data_a : '0;
    assign alu_b      = v1 ? rd_data_b : '0;
    assign alu_opcode = op_q;
    assign alu_q      = q_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_vec_op_seq.sv
// Bench for vec_op_seq: scratchpad + ALU environment, reference model
// of addressing and timing, randomized and directed scenarios.
module tb_vec_op_seq;

    localparam int MS = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode = '0;
    logic [9:0]  cmd_src_a = '0;
    logic [9:0]  cmd_src_b = '0;
    logic [9:0]  cmd_dst = '0;
    logic [10:0] cmd_len = '0;
    logic [63:0] cmd_q = '0;
    logic        rd_en;
    logic [9:0]  rd_addr_a;
    logic [9:0]  rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [2:0]  alu_opcode;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [63:0] alu_q;
    logic [63:0] alu_res;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [63:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    vec_op_seq #(.ADDR_W(10), .LEN_W(11)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_src_a(cmd_src_a),
        .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .cmd_len(cmd_len), .cmd_q(cmd_q),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_q(alu_q), .alu_res(alu_res),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] alu_f(input logic [2:0] op,
        input logic [63:0] a, input logic [63:0] b, input logic [63:0] q);
        logic [127:0] x, y, m, r;
        if (q == 64'd0) return '0;
        m = {64'd0, q};
        x = {64'd0, a} % m;
        y = {64'd0, b} % m;
        case (op)
            3'd0:    r = (x + y) % m;
            3'd1:    r = (x + m - y) % m;
            3'd2:    r = (x * y) % m;
            default: r = '0;
        endcase
        return r[63:0];
    endfunction

    // Scratchpad (old data on same-cycle read/write) and combinational ALU
    logic [63:0] mem [MS];
    logic [63:0] seedmem [MS];
    logic [63:0] rmem [MS];
    logic        init_req = 1'b0;

    always @(posedge clk) begin
        if (init_req) begin
            for (int i = 0; i < MS; i++) mem[i] <= seedmem[i];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_a <= mem[rd_addr_a];
            rd_data_b <= mem[rd_addr_b];
        end
    end

    always_comb alu_res = alu_f(alu_opcode, alu_a, alu_b, alu_q);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          wc[$], dc[$], acq[$];
    logic [9:0]  wa[$], ra[$];
    logic [63:0] wd[$];
    logic        de[$], dr[$];
    int          rd_n, busy_n;
    int          ec[$], edc[$];
    logic [9:0]  ea[$];
    logic [63:0] ed[$];
    logic        ede[$], edr[$];
    int          erd;
    int          total = 0;
    int          bad = 0;

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) acq.push_back(cyc);
        if (rd_en) begin
            rd_n++;
            ra.push_back(rd_addr_a);
        end
        if (busy) busy_n++;
        if (wr_en) begin
            wc.push_back(cyc);
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
        if (done) begin
            dc.push_back(cyc);
            de.push_back(err);
            dr.push_back(cmd_ready);
        end
    end

    task automatic clr();
        wc.delete(); dc.delete(); acq.delete(); wa.delete(); ra.delete();
        wd.delete(); de.delete(); dr.delete();
        ec.delete(); edc.delete(); ea.delete(); ed.delete();
        ede.delete(); edr.delete();
        rd_n = 0; busy_n = 0; erd = 0;
    endtask

    task automatic push_mem();
        seedmem = rmem;
        @(posedge clk); #1 init_req = 1'b1;
        @(posedge clk); #1 init_req = 1'b0;
    endtask

    task automatic present(input logic [2:0] op, input logic [9:0] sa,
        input logic [9:0] sb, input logic [9:0] d, input logic [10:0] len,
        input logic [63:0] q);
        cmd_opcode = op; cmd_src_a = sa; cmd_src_b = sb;
        cmd_dst = d; cmd_len = len; cmd_q = q; cmd_valid = 1'b1;
    endtask

    task automatic wait_acc(output int a);
        a = -1;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (cmd_ready && cmd_valid) begin
                a = cyc;
                break;
            end
        end
        if (a < 0) begin
            total++; bad++;
            $display("FAIL accept: no cmd_ready within 300 cycles");
        end
    endtask

    // Reference: element i = op(A[sa+i], B[sb+i]) mod q, written to dst+i
    // with addresses wrapping mod 1024; writes in acc+3+i, done at acc+len+3.
    task automatic model(input logic [2:0] op, input logic [9:0] sa,
        input logic [9:0] sb, input logic [9:0] d, input int len,
        input logic [63:0] q, input int acc, input int nwr);
        logic [63:0] r[$];
        for (int i = 0; i < nwr; i++)
            r.push_back(alu_f(op, rmem[(int'(sa) + i) % MS],
                              rmem[(int'(sb) + i) % MS], q));
        for (int i = 0; i < nwr; i++) begin
            rmem[(int'(d) + i) % MS] = r[i];
            ec.push_back(acc + 3 + i);
            ea.push_back(10'((int'(d) + i) % MS));
            ed.push_back(r[i]);
        end
        erd += len;
        if (nwr == len) begin
            edc.push_back(acc + len + 3);
            ede.push_back(1'b0);
            edr.push_back(1'b1);
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rd_en, wr_en, done, err, busy, cmd_ready, alu_opcode, alu_q,
             wr_data, wr_addr, rd_addr_a, rd_addr_b, alu_a, alu_b} !== '0) begin
            bad++;
            $display("FAIL reset_outs: outputs not all zero in reset");
        end
        for (int i = 0; i < MS; i++) begin
            rmem[i] = {$urandom, $urandom};
        end
        push_mem();
        @(posedge clk); #1 rst_n = 1'b1;
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_rdy0: got %b want 0", cmd_ready);
        end
        @(posedge clk); #1;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_rdy1: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_add();
        int a;
        logic [63:0] va[4], vb[4];
        va = '{64'd1, 64'd5, 64'd16, 64'd0};
        vb = '{64'd2, 64'd12, 64'd3, 64'd0};
        for (int i = 0; i < 4; i++) begin
            rmem[10 + i] = va[i];
            rmem[20 + i] = vb[i];
        end
        push_mem();
        clr();
        @(posedge clk); #1 present(3'd0, 10'd10, 10'd20, 10'd30, 11'd4, 64'd17);
        wait_acc(a);
        model(3'd0, 10'd10, 10'd20, 10'd30, 4, 64'd17, a, 4);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (wc.size() != ec.size()) begin
            bad++;
            $display("FAIL add_nwr: got %0d want %0d", wc.size(), ec.size());
        end
        for (int k = 0; k < wc.size() && k < ec.size(); k++) begin
            total++;
            if (wc[k] !== ec[k] || wa[k] !== ea[k] || wd[k] !== ed[k]) begin
                bad++;
                $display("FAIL add_wr%0d: got c%0d a%0d d%0h want c%0d a%0d d%0h",
                    k, wc[k], wa[k], wd[k], ec[k], ea[k], ed[k]);
            end
        end
        total++;
        if (dc.size() != 1 || dc[0] !== edc[0] || de[0] !== 1'b0 || dr[0] !== 1'b1) begin
            bad++;
            $display("FAIL add_done: got n%0d c%0d want n1 c%0d err0 rdy1",
                dc.size(), (dc.size() > 0) ? dc[0] : -1, edc[0]);
        end
        total++;
        if (rd_n !== erd || busy_n !== 6) begin
            bad++;
            $display("FAIL add_counts: got rd%0d busy%0d want rd%0d busy6",
                rd_n, busy_n, erd);
        end
        total++;
        if (mem[30] !== 64'd3 || mem[31] !== 64'd0 || mem[32] !== 64'd2 || mem[33] !== 64'd0) begin
            bad++;
            $display("FAIL add_mem: got %0d %0d %0d %0d want 3 0 2 0",
                mem[30], mem[31], mem[32], mem[33]);
        end
    endtask

    task automatic test_b2b();
        int a1, a2;
        rmem[40] = 64'd50;
        rmem[41] = 64'd3;
        push_mem();
        clr();
        @(posedge clk); #1 present(3'd2, 10'd40, 10'd41, 10'd42, 11'd1, 64'd97);
        wait_acc(a1);
        model(3'd2, 10'd40, 10'd41, 10'd42, 1, 64'd97, a1, 1);
        @(posedge clk); #1 present(3'd1, 10'd50, 10'd60, 10'd70, 11'd3, 64'd97);
        wait_acc(a2);
        model(3'd1, 10'd50, 10'd60, 10'd70, 3, 64'd97, a2, 3);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (a2 !== a1 + 4) begin
            bad++;
            $display("FAIL b2b_acc: got %0d want %0d", a2, a1 + 4);
        end
        total++;
        if (mem[42] !== 64'd53) begin
            bad++;
            $display("FAIL b2b_mult: got %0d want 53", mem[42]);
        end
        total++;
        if (wc.size() != ec.size()) begin
            bad++;
            $display("FAIL b2b_nwr: got %0d want %0d", wc.size(), ec.size());
        end
        for (int k = 0; k < wc.size() && k < ec.size(); k++) begin
            total++;
            if (wc[k] !== ec[k] || wa[k] !== ea[k] || wd[k] !== ed[k]) begin
                bad++;
                $display("FAIL b2b_wr%0d: got c%0d a%0d d%0h want c%0d a%0d d%0h",
                    k, wc[k], wa[k], wd[k], ec[k], ea[k], ed[k]);
            end
        end
        total++;
        if (dc.size() != 2 || dc[0] !== edc[0] || dc[1] !== edc[1]) begin
            bad++;
            $display("FAIL b2b_done: got n%0d want 2 at %0d,%0d", dc.size(), edc[0], edc[1]);
        end
    endtask

    task automatic test_wrap();
        int a;
        logic [9:0] exp_ra[4];
        exp_ra = '{10'd1022, 10'd1023, 10'd0, 10'd1};
        clr();
        @(posedge clk); #1 present(3'd0, 10'd1022, 10'd100, 10'd1022, 11'd4, 64'hffff_fff1);
        wait_acc(a);
        model(3'd0, 10'd1022, 10'd100, 10'd1022, 4, 64'hffff_fff1, a, 4);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (ra.size() != 4 || ra[0] !== exp_ra[0] || ra[1] !== exp_ra[1] ||
            ra[2] !== exp_ra[2] || ra[3] !== exp_ra[3]) begin
            bad++;
            $display("FAIL wrap_rd: got %0d reads want 1022 1023 0 1", ra.size());
        end
        total++;
        if (wc.size() != ec.size()) begin
            bad++;
            $display("FAIL wrap_nwr: got %0d want %0d", wc.size(), ec.size());
        end
        for (int k = 0; k < wc.size() && k < ec.size(); k++) begin
            total++;
            if (wc[k] !== ec[k] || wa[k] !== ea[k] || wd[k] !== ed[k]) begin
                bad++;
                $display("FAIL wrap_wr%0d: got c%0d a%0d d%0h want c%0d a%0d d%0h",
                    k, wc[k], wa[k], wd[k], ec[k], ea[k], ed[k]);
            end
        end
    endtask

    task automatic test_zero_illegal();
        int a;
        logic [2:0]  ops[2];
        logic [10:0] lens[2];
        ops  = '{3'd0, 3'd5};
        lens = '{11'd0, 11'd8};
        for (int t = 0; t < 2; t++) begin
            clr();
            @(posedge clk); #1 present(ops[t], 10'd5, 10'd6, 10'd7, lens[t], 64'd13);
            wait_acc(a);
            @(posedge clk); #1 cmd_valid = 1'b0;
            @(negedge clk);
            total++;
            if (cyc !== a + 1 || done !== 1'b1 || err !== t[0] ||
                cmd_ready !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL quick%0d_c1: got done%b err%b rdy%b busy%b want 1 %0d 0 0",
                    t, done, err, cmd_ready, busy, t);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || cmd_ready !== 1'b1 || alu_opcode !== ops[t]) begin
                bad++;
                $display("FAIL quick%0d_c2: got done%b rdy%b op%0d want 0 1 %0d",
                    t, done, cmd_ready, alu_opcode, ops[t]);
            end
            repeat (10) @(negedge clk);
            total++;
            if (rd_n !== 0 || wc.size() != 0 || busy_n !== 0 || dc.size() != 1) begin
                bad++;
                $display("FAIL quick%0d_traffic: got rd%0d wr%0d busy%0d done%0d want 0 0 0 1",
                    t, rd_n, wc.size(), busy_n, dc.size());
            end
        end
    endtask

    task automatic test_reset_mid();
        int a, b;
        clr();
        @(posedge clk); #1 present(3'd2, 10'd100, 10'd300, 10'd600, 11'd16, 64'd1000003);
        wait_acc(a);
        model(3'd2, 10'd100, 10'd300, 10'd600, 16, 64'd1000003, a, 1);
        erd = 3;
        @(posedge clk); #1 cmd_valid = 1'b0;
        while (cyc < a + 4) begin
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({rd_en, wr_en, done, err, busy, cmd_ready, alu_opcode, alu_q,
             wr_data, wr_addr, rd_addr_a, rd_addr_b, alu_a, alu_b} !== '0) begin
            bad++;
            $display("FAIL rmid_outs: outputs not all zero after async reset");
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (wc.size() != 1 || dc.size() != 0 || rd_n !== erd) begin
            bad++;
            $display("FAIL rmid_abandon: got wr%0d done%0d rd%0d want 1 0 3",
                wc.size(), dc.size(), rd_n);
        end
        total++;
        if (wc.size() > 0 && (wc[0] !== ec[0] || wa[0] !== ea[0] || wd[0] !== ed[0])) begin
            bad++;
            $display("FAIL rmid_wr0: got c%0d a%0d d%0h want c%0d a%0d d%0h",
                wc[0], wa[0], wd[0], ec[0], ea[0], ed[0]);
        end
        clr();
        @(posedge clk); #1 present(3'd1, 10'd100, 10'd300, 10'd100, 11'd8, 64'd65537);
        wait_acc(b);
        model(3'd1, 10'd100, 10'd300, 10'd100, 8, 64'd65537, b, 8);
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (16) @(negedge clk);
        total++;
        if (wc.size() != ec.size()) begin
            bad++;
            $display("FAIL rmid_fresh_nwr: got %0d want %0d", wc.size(), ec.size());
        end
        for (int k = 0; k < wc.size() && k < ec.size(); k++) begin
            total++;
            if (wc[k] !== ec[k] || wa[k] !== ea[k] || wd[k] !== ed[k]) begin
                bad++;
                $display("FAIL rmid_fresh_wr%0d: got c%0d a%0d d%0h want c%0d a%0d d%0h",
                    k, wc[k], wa[k], wd[k], ec[k], ea[k], ed[k]);
            end
        end
        total++;
        if (dc.size() != 1 || dc[0] !== edc[0] || de[0] !== 1'b0) begin
            bad++;
            $display("FAIL rmid_fresh_done: got n%0d want 1 at %0d", dc.size(), edc[0]);
        end
    endtask

    task automatic test_hold_random();
        logic [2:0]  op[6];
        logic [9:0]  sa[6], sb[6], d[6];
        logic [10:0] ln[6];
        logic [63:0] q[6];
        int          a[6];
        for (int j = 0; j < 6; j++) begin
            op[j] = 3'($urandom_range(0, 2));
            ln[j] = 11'($urandom_range(1, 24));
            sa[j] = 10'($urandom_range(0, 230));
            sb[j] = 10'($urandom_range(256, 480));
            d[j]  = ($urandom_range(0, 2) == 0) ? sa[j] : 10'($urandom_range(512, 990));
            q[j]  = {$urandom, $urandom} | 64'h1;
        end
        clr();
        @(posedge clk); #1 present(op[0], sa[0], sb[0], d[0], ln[0], q[0]);
        for (int j = 0; j < 6; j++) begin
            wait_acc(a[j]);
            model(op[j], sa[j], sb[j], d[j], int'(ln[j]), q[j], a[j], int'(ln[j]));
            @(posedge clk); #1;
            if (j < 5) present(op[j+1], sa[j+1], sb[j+1], d[j+1], ln[j+1], q[j+1]);
            else cmd_valid = 1'b0;
        end
        repeat (40) @(negedge clk);
        total++;
        if (acq.size() != 6) begin
            bad++;
            $display("FAIL hold_accepts: got %0d want 6", acq.size());
        end
        for (int j = 1; j < 6; j++) begin
            total++;
            if (a[j] !== a[j-1] + int'(ln[j-1]) + 3) begin
                bad++;
                $display("FAIL hold_gap%0d: got %0d want %0d", j, a[j], a[j-1] + int'(ln[j-1]) + 3);
            end
        end
        total++;
        if (wc.size() != ec.size()) begin
            bad++;
            $display("FAIL hold_nwr: got %0d want %0d", wc.size(), ec.size());
        end
        for (int k = 0; k < wc.size() && k < ec.size(); k++) begin
            total++;
            if (wc[k] !== ec[k] || wa[k] !== ea[k] || wd[k] !== ed[k]) begin
                bad++;
                $display("FAIL hold_wr%0d: got c%0d a%0d d%0h want c%0d a%0d d%0h",
                    k, wc[k], wa[k], wd[k], ec[k], ea[k], ed[k]);
            end
        end
        total++;
        if (dc.size() != edc.size()) begin
            bad++;
            $display("FAIL hold_ndone: got %0d want %0d", dc.size(), edc.size());
        end
        for (int k = 0; k < dc.size() && k < edc.size(); k++) begin
            total++;
            if (dc[k] !== edc[k] || de[k] !== ede[k] || dr[k] !== edr[k]) begin
                bad++;
                $display("FAIL hold_done%0d: got c%0d e%b r%b want c%0d e%b r%b",
                    k, dc[k], de[k], dr[k], edc[k], ede[k], edr[k]);
            end
        end
        total++;
        if (rd_n !== erd) begin
            bad++;
            $display("FAIL hold_reads: got %0d want %0d", rd_n, erd);
        end
    endtask

    task automatic test_final_mem();
        int diff = 0;
        for (int i = 0; i < MS; i++)
            if (mem[i] !== rmem[i]) diff++;
        total++;
        if (diff != 0) begin
            bad++;
            $display("FAIL final_mem: got %0d differing words want 0", diff);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_b2b();
        test_wrap();
        test_zero_illegal();
        test_reset_mid();
        test_hold_random();
        test_final_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
